// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the NPC core sequencer.
//   npc_state_e  - sequencer state encoding (FETCH, EXEC, WB, HALT)
//   EXIT_*       - exit codes reported on halt
//   INST_EBREAK  - encoding of the ebreak instruction (simulation-end trap)
package npc_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_HALT  = 2'd3
  } npc_state_e;

  localparam logic [1:0] EXIT_RUN     = 2'b00;
  localparam logic [1:0] EXIT_GOOD    = 2'b01;
  localparam logic [1:0] EXIT_BAD     = 2'b10;
  localparam logic [1:0] EXIT_TIMEOUT = 2'b11;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/npc_watchdog.sv
// npc_watchdog: fetch-wait counter with clear, enable and terminal count.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (has priority over en)
//   en       : count one wait cycle
//   tc       : high when the current wait cycle is the LIMIT-th one, so a
//              wait in this cycle means LIMIT consecutive waits have elapsed
module npc_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // cnt holds the number of waits already seen; the next wait is number cnt+1.
  assign tc = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/npc_ctrl.sv
// npc_ctrl: multi-cycle FETCH/EXEC/WB sequencer for the NPC core with
// sticky simulation-end halt.
//   clk, rst           : clock, asynchronous active-high reset
//   ifu_req/ifu_addr   : fetch request (high in FETCH) and address (= pc)
//   ifu_valid/ifu_inst : fetch response, only honoured in FETCH
//   inst               : latched instruction for decode/execute
//   illegal, overflow  : decode/execute trap flags, sampled in EXEC
//   a0                 : x10, selects GOOD/BAD verdict on ebreak
//   next_pc            : successor PC, committed in WB
//   rf_we              : register-file write enable, high in WB only
//   pc                 : current PC
//   halted, exit_code  : sticky halt flag and its reason
//   cycle_cnt, instret : non-halt cycle count and retired-instruction count
//   dbg_state          : current sequencer state (npc_state_e encoding)
//
// Handshake: ifu_req is high for every FETCH cycle; a cycle in FETCH with
// ifu_valid high transfers ifu_inst and ends the fetch. There is no
// backpressure on the response side and ifu_valid in any other state is
// ignored.
module npc_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int          FETCH_TIMEOUT = 255,
  parameter int          CNT_W         = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req,
  output logic [31:0]      ifu_addr,
  input  logic             ifu_valid,
  input  logic [31:0]      ifu_inst,
  output logic [31:0]      inst,
  input  logic             illegal,
  input  logic             overflow,
  input  logic [31:0]      a0,
  input  logic [31:0]      next_pc,
  output logic             rf_we,
  output logic [31:0]      pc,
  output logic             halted,
  output logic [1:0]       exit_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret,
  output logic [1:0]       dbg_state
);

  npc_state_e state_q, state_d;
  logic [1:0] exit_d;
  logic       load_inst;
  logic       wd_tc;

  npc_watchdog #(.LIMIT(FETCH_TIMEOUT)) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_WB),
    .en  ((state_q == ST_FETCH) && !ifu_valid),
    .tc  (wd_tc)
  );

  always_comb begin
    state_d   = state_q;
    exit_d    = exit_code;
    load_inst = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // A response in the last allowed wait cycle still wins over timeout.
        if (ifu_valid) begin
          state_d   = ST_EXEC;
          load_inst = 1'b1;
        end else if (wd_tc) begin
          state_d = ST_HALT;
          exit_d  = EXIT_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (inst == INST_EBREAK) begin
          state_d = ST_HALT;
          exit_d  = (a0 == 32'd0) ? EXIT_GOOD : EXIT_BAD;
        end else if (illegal || overflow) begin
          state_d = ST_HALT;
          exit_d  = EXIT_BAD;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc        <= RESET_PC;
      inst      <= '0;
      exit_code <= EXIT_RUN;
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      state_q   <= state_d;
      exit_code <= exit_d;
      if (load_inst) begin
        inst <= ifu_inst;
      end
      // Only WB commits, so trapping instructions never touch pc/instret.
      if (state_q == ST_WB) begin
        pc      <= next_pc;
        instret <= instret + 1'b1;
      end
      if (state_q != ST_HALT) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

  assign ifu_req   = (state_q == ST_FETCH);
  assign ifu_addr  = pc;
  assign rf_we     = (state_q == ST_WB);
  assign halted    = (state_q == ST_HALT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_npc_ctrl.sv
// Directed bench for npc_ctrl with a small reference model and an expected
// retirement queue. Inputs change on the falling edge, outputs are sampled
// on the falling edge.
module tb_npc_ctrl;
  import npc_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TMO    = 4;
  localparam int          CW     = 64;
  localparam logic [31:0] ADDI1  = 32'h0010_0093;
  localparam logic [31:0] ADDI2  = 32'h0020_0113;

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ifu_req, ifu_valid, illegal, overflow, rf_we, halted;
  logic [31:0]   ifu_addr, ifu_inst, inst, a0, next_pc, pc;
  logic [1:0]    exit_code, dbg_state;
  logic [CW-1:0] cycle_cnt, instret;

  npc_ctrl #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_addr(ifu_addr),
    .ifu_valid(ifu_valid), .ifu_inst(ifu_inst), .inst(inst),
    .illegal(illegal), .overflow(overflow), .a0(a0), .next_pc(next_pc),
    .rf_we(rf_we), .pc(pc), .halted(halted), .exit_code(exit_code),
    .cycle_cnt(cycle_cnt), .instret(instret), .dbg_state(dbg_state)
  );

  // scoreboard / model state
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic [63:0] exp_cycles;
  logic [63:0] exp_instret;
  logic [1:0]  exp_code;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Assert rst mid-cycle, check async values, hold across one edge, release.
  task automatic do_reset();
    #2;
    rst = 1'b1; ifu_valid = 1'b0; illegal = 1'b0; overflow = 1'b0;
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_instret", instret, 0);
    chk("rst_cycles", cycle_cnt, 0);
    chk("rst_rf_we", rf_we, 0);
    @(negedge clk);
    chk("rst_req", ifu_req, 1);
    chk("rst_halted", halted, 0);
    chk("rst_exit", exit_code, EXIT_RUN);
    chk("rst_inst", inst, 0);
    chk("rst_state", dbg_state, ST_FETCH);
    chk("rst_cycles_held", cycle_cnt, 0);
    rst = 1'b0;
    exp_pc = RST_PC; exp_inst = '0; exp_cycles = 0; exp_instret = 0;
    exp_code = EXIT_RUN;
    exp_q.delete();
  endtask

  // Drive one instruction from a FETCH falling edge to WB completion or halt.
  task automatic do_inst(input logic [31:0] word, input int waits,
                         input logic ill, input logic ovf, input logic [31:0] a0v);
    logic        trap;
    logic [1:0]  code;
    logic [31:0] nxt, popped;
    nxt = exp_pc + 32'd4;
    chk("fetch_req", ifu_req, 1);
    chk("fetch_addr", ifu_addr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      ifu_valid = 1'b0;
      @(negedge clk); exp_cycles++;
      chk("wait_halted", halted, 0);
      chk("wait_req", ifu_req, 1);
    end
    ifu_valid = 1'b1; ifu_inst = word; illegal = ill; overflow = ovf;
    a0 = a0v; next_pc = nxt;
    trap = 1'b1; code = EXIT_BAD;
    if (word == INST_EBREAK) code = (a0v == 0) ? EXIT_GOOD : EXIT_BAD;
    else if (!ill && !ovf) trap = 1'b0;
    if (!trap) exp_q.push_back(nxt);
    @(negedge clk); exp_cycles++;
    // stray responses outside FETCH must be ignored
    ifu_valid = 1'b1; ifu_inst = $urandom;
    chk("exec_inst", inst, word);
    chk("exec_req", ifu_req, 0);
    chk("exec_rf_we", rf_we, 0);
    @(negedge clk); exp_cycles++;
    ifu_valid = 1'(($urandom_range(0, 1)));
    exp_inst = word;
    if (trap) begin
      exp_code = code;
      chk("trap_halted", halted, 1);
      chk("trap_exit", exit_code, code);
      chk("trap_pc", pc, exp_pc);
      chk("trap_rf_we", rf_we, 0);
      chk("trap_instret", instret, exp_instret);
      chk("trap_cycles", cycle_cnt, exp_cycles);
    end else begin
      chk("wb_rf_we", rf_we, 1);
      chk("wb_halted", halted, 0);
      chk("wb_inst", inst, word);
      popped = exp_q.pop_front();
      @(negedge clk); exp_cycles++;
      exp_pc = popped; exp_instret++;
      chk("ret_pc", pc, popped);
      chk("ret_instret", instret, exp_instret);
      chk("ret_cycles", cycle_cnt, exp_cycles);
      chk("ret_rf_we", rf_we, 0);
      chk("ret_exit", exit_code, EXIT_RUN);
    end
  endtask

  // A few cycles in HALT with random fetch responses: nothing may move.
  task automatic halt_idle(input int n);
    for (int i = 0; i < n; i++) begin
      ifu_valid = 1'(($urandom_range(0, 1))); ifu_inst = $urandom;
      @(negedge clk);
      chk("halt_req", ifu_req, 0);
      chk("halt_rf_we", rf_we, 0);
      chk("halt_flag", halted, 1);
      chk("halt_pc", pc, exp_pc);
      chk("halt_inst", inst, exp_inst);
      chk("halt_cycles", cycle_cnt, exp_cycles);
      chk("halt_exit", exit_code, exp_code);
    end
  endtask

  initial begin
    ifu_valid = 1'b0; ifu_inst = '0; illegal = 1'b0; overflow = 1'b0;
    a0 = '0; next_pc = '0;
    @(negedge clk);
    do_reset();

    // addi, addi, ebreak(a0=0): halt seen in cycle 9 after 8 counted cycles
    do_inst(ADDI1, 0, 1'b0, 1'b0, $urandom);
    do_inst(ADDI2, 0, 1'b0, 1'b0, $urandom);
    do_inst(INST_EBREAK, 0, 1'b0, 1'b0, 32'd0);
    chk("t1_pc", pc, 32'h8000_0008);
    chk("t1_instret", instret, 2);
    chk("t1_cycles", cycle_cnt, 8);
    chk("t1_exit", exit_code, 2'b01);
    halt_idle(3);

    // ebreak with a0 != 0
    do_reset();
    do_inst(INST_EBREAK, 0, 1'b0, 1'b0, 32'd1);
    chk("t2_pc", pc, 32'h8000_0000);
    chk("t2_exit", exit_code, 2'b10);
    halt_idle(2);

    // illegal on the second instruction
    do_reset();
    do_inst(ADDI1, 0, 1'b0, 1'b0, 32'd0);
    do_inst(ADDI2, 0, 1'b1, 1'b0, 32'd0);
    chk("t3_pc", pc, 32'h8000_0004);
    chk("t3_instret", instret, 1);
    halt_idle(2);

    // overflow after a waited fetch
    do_reset();
    do_inst(ADDI1, 2, 1'b0, 1'b0, 32'd5);
    do_inst(ADDI2, 1, 1'b0, 1'b1, 32'd0);
    chk("t4_exit", exit_code, 2'b10);
    halt_idle(2);

    // ebreak takes priority over illegal
    do_reset();
    do_inst(INST_EBREAK, 0, 1'b1, 1'b1, 32'd0);
    chk("t5_exit", exit_code, 2'b01);

    // fetch timeout: no response for TMO FETCH cycles
    do_reset();
    ifu_valid = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk); exp_cycles++;
      chk("tmo_halted", halted, (i == TMO) ? 1 : 0);
    end
    exp_code = EXIT_TIMEOUT;
    chk("tmo_exit", exit_code, 2'b11);
    chk("tmo_cycles", cycle_cnt, 4);
    chk("tmo_pc", pc, RST_PC);
    halt_idle(2);

    // response in the last allowed wait cycle, twice (watchdog cleared in WB)
    do_reset();
    do_inst(ADDI1, TMO - 1, 1'b0, 1'b0, 32'd0);
    do_inst(ADDI2, TMO - 1, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      do_inst($urandom & 32'hFFF0_0FFF, $urandom_range(0, TMO - 1), 1'b0, 1'b0, $urandom);
    end
    do_inst(INST_EBREAK, 0, 1'b0, 1'b0, 32'd0);
    chk("t7_instret", instret, 6);
    chk("t7_exit", exit_code, EXIT_GOOD);

    // reset mid-WB
    do_reset();
    do_inst(ADDI1, 0, 1'b0, 1'b0, 32'd0);
    ifu_valid = 1'b1; ifu_inst = ADDI2; next_pc = 32'h1234_5678;
    @(negedge clk);
    ifu_valid = 1'b0;
    @(negedge clk);
    chk("mwb_rf_we", rf_we, 1);
    #2 rst = 1'b1;
    #1;
    chk("mwb_pc", pc, RST_PC);
    chk("mwb_instret", instret, 0);
    chk("mwb_cycles", cycle_cnt, 0);
    chk("mwb_rf_we_after", rf_we, 0);
    @(negedge clk);
    chk("mwb_rf_we_held", rf_we, 0);
    chk("mwb_pc_held", pc, RST_PC);
    rst = 1'b0;
    exp_pc = RST_PC; exp_cycles = 0; exp_instret = 0; exp_q.delete();

    // reset mid-FETCH (during waits)
    ifu_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mf_cycles_pre", cycle_cnt, 2);
    do_reset();
    do_inst(ADDI1, 3, 1'b0, 1'b0, 32'd0);
    chk("mf_pc", pc, 32'h8000_0004);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
